// File: rtl/mcpu_kbd_pkg.sv
// Shared types and constants for the MCPU PS/2 keyboard receiver.
package mcpu_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } kbd_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic       PS2_IDLE_LEVEL = 1'b1;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/mcpu_kbd_ps2_if.sv
// Keyboard-side bus: raw PS/2 pins, CPU pop request and receiver status.
interface mcpu_kbd_ps2_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_ack;
  logic [7:0] keycode;
  logic       key_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  modport master (
    output ps2_clk, ps2_data, key_ack,
    input  keycode, key_valid, parity_err, frame_err, overflow
  );

  modport slave (
    input  ps2_clk, ps2_data, key_ack,
    output keycode, key_valid, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/mcpu_kbd_fifo.sv
// Synchronous scan-code FIFO; head is shown combinationally from storage, 0 when empty.
module mcpu_kbd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= overflow | (push & ~do_push);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mcpu_kbd_ps2.sv
// PS/2 keyboard receiver: pin sync, frame FSM with timeout, checks, scan-code FIFO.
// Optional MCPU_KBD_BREAK_FILTER_EN drops F0 break prefixes and the byte following them.
module mcpu_kbd_ps2 #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic          clk,
  input  logic          reset,
  mcpu_kbd_ps2_if.slave bus
);
  import mcpu_kbd_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_s;
  logic [1:0]    data_s;
  logic          clk_prev;
  logic          sample;
  logic          bit_in;

  kbd_state_e    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push_q, push_d;
  logic [7:0]    push_byte_q;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          empty;
  logic [7:0]    head;
  logic          ovf;
`ifdef MCPU_KBD_BREAK_FILTER_EN
  logic          brk_q, brk_d;
`endif

  // Two-flop synchronisers plus edge-detect flop; falling ps2_clk is the sample event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s    <= {2{PS2_IDLE_LEVEL}};
      data_s   <= {2{PS2_IDLE_LEVEL}};
      clk_prev <= PS2_IDLE_LEVEL;
    end else begin
      clk_s    <= {clk_s[0], bus.ps2_clk};
      data_s   <= {data_s[0], bus.ps2_data};
      clk_prev <= clk_s[1];
    end
  end

  assign sample = clk_prev & ~clk_s[1];
  assign bit_in = data_s[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef MCPU_KBD_BREAK_FILTER_EN
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      push_q  <= push_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      if (push_d) push_byte_q <= shift_q;
`ifdef MCPU_KBD_BREAK_FILTER_EN
      brk_q   <= brk_d;
`endif
    end
  end

  // Frame FSM: next state, datapath updates and push/error decisions
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tmo_d   = '0;
    push_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef MCPU_KBD_BREAK_FILTER_EN
    brk_d   = brk_q;
`endif
    if (state_q != ST_IDLE) tmo_d = tmo_q + TW'(1);

    if (sample) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          if (cnt_q == 3'd7) state_d = ST_PARITY;
          else               cnt_d   = cnt_q + 3'd1;
        end
        ST_PARITY: begin
          par_d   = bit_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!bit_in) begin
            ferr_d = 1'b1;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
          end else begin
`ifdef MCPU_KBD_BREAK_FILTER_EN
            if (brk_q)                        brk_d  = 1'b0;
            else if (shift_q == PS2_BREAK)    brk_d  = 1'b1;
            else                              push_d = 1'b1;
`else
            push_d = 1'b1;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      // Partial frame abandoned silently
      state_d = ST_IDLE;
      tmo_d   = '0;
`ifdef MCPU_KBD_BREAK_FILTER_EN
      brk_d   = 1'b0;
`endif
    end
  end

  mcpu_kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_q),
    .pop      (bus.key_ack),
    .din      (push_byte_q),
    .dout     (head),
    .empty    (empty),
    .overflow (ovf)
  );

  assign bus.keycode    = head;
  assign bus.key_valid  = ~empty;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf;

endmodule
